serial_addsub: RTL and testbench

- Multi-cycle bit-serial adder/subtractor for the execute stage's low-area arithmetic path.
- Processes SLICE bits per cycle, LSB first, with one registered carry; produces a WIDTH-bit result plus LEGv8-style NZVC flags.
- Uses a start/busy/done handshake so the pipeline control can stall while it runs.
- Subtraction is A + ~B + 1, so carry=1 means no borrow.

---
 rtl/addsub_pkg.sv | 7 +
 rtl/serial_addsub_cell.sv | 15 +
 rtl/serial_addsub.sv | 100 ++++++++++
 tb/tb_serial_addsub.sv | 139 +++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared states, default sizes and carry type for serial_addsub
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 1;
  typedef logic carry_t;
endpackage

// File: rtl/serial_addsub_cell.sv
// serial_addsub_cell: SLICE-bit ripple add producing sum, carry out and carry into the slice MSB
module serial_addsub_cell #(parameter int SLICE = 1) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [SLICE:0] t;
  assign t = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  assign s = t[SLICE-1:0];
  assign cout = t[SLICE];
  assign c_msb_in = a[SLICE-1] ^ b[SLICE-1] ^ s[SLICE-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/sub with NZVC flags and start/busy/done handshake; abort port when SERIAL_ADDSUB_ABORT_EN is defined
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);
  localparam int N = WIDTH / SLICE;
  localparam int CW = $clog2(N) + 1;
  if (WIDTH % SLICE != 0 || !(SLICE == 1 || SLICE == 2 || SLICE == 4 || SLICE == 8)) begin : g_bad_slice
    $error("serial_addsub: SLICE must be 1, 2, 4 or 8 and divide WIDTH");
  end
  state_t state;
  logic [WIDTH-1:0] sa, sb, sr, nsr;
  logic [CW-1:0] cnt;
  carry_t carry;
  logic [SLICE-1:0] s;
  logic cout, c_msb_in, abort_run;
  serial_addsub_cell #(.SLICE(SLICE)) u_cell (
    .a(sa[SLICE-1:0]),
    .b(sb[SLICE-1:0]),
    .cin(carry),
    .s(s),
    .cout(cout),
    .c_msb_in(c_msb_in)
  );
  assign nsr = {s, sr[WIDTH-1:SLICE]};
`ifdef SERIAL_ADDSUB_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      negative <= 1'b0;
      zero <= 1'b0;
      overflow <= 1'b0;
      carry_out <= 1'b0;
      carry <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sa <= A;
          sb <= sub ? ~B : B;
          carry <= sub;
          cnt <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: if (abort_run) begin
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          sa <= sa >> SLICE;
          sb <= sb >> SLICE;
          sr <= nsr;
          carry <= cout;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            done <= 1'b1;
            result <= nsr;
            negative <= nsr[WIDTH-1];
            zero <= ~|nsr;
            carry_out <= cout;
            overflow <= c_msb_in ^ cout;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random checks of serial_addsub against an arithmetic reference
module tb_serial_addsub;
  logic clk = 0, reset = 1, start0 = 0, start1 = 0, sub = 0, sel = 0;
`ifdef SERIAL_ADDSUB_ABORT_EN
  logic abort = 0;
`endif
  logic [63:0] A = 0, B = 0;
  logic busy0, done0, n0, z0, v0, c0, busy1, done1, n1, z1, v1, c1;
  logic [63:0] r0, r1;
  logic o_busy, o_done;
  logic [63:0] o_result;
  logic [3:0] o_flags;
  logic [63:0] prev [2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_addsub #(.WIDTH(64), .SLICE(1)) d0 (
    .clk(clk), .reset(reset), .start(start0),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort(abort),
`endif
    .sub(sub), .A(A), .B(B), .busy(busy0), .done(done0), .result(r0),
    .negative(n0), .zero(z0), .overflow(v0), .carry_out(c0)
  );
  serial_addsub #(.WIDTH(64), .SLICE(8)) d1 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort(1'b0),
`endif
    .sub(sub), .A(A), .B(B), .busy(busy1), .done(done1), .result(r1),
    .negative(n1), .zero(z1), .overflow(v1), .carry_out(c1)
  );
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_result = sel ? r1 : r0;
  assign o_flags = sel ? {n1, z1, v1, c1} : {n0, z0, v0, c0};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [63:0] a, input logic [63:0] b, input logic s, input int mid);
    logic [64:0] t;
    logic [63:0] r;
    logic v;
    int n, bc, lat;
    lat = sel ? 9 : 65;
    t = {1'b0, a} + {1'b0, s ? ~b : b} + 65'(s);
    r = t[63:0];
    v = s ? (a[63] != b[63] && r[63] != a[63]) : (a[63] == b[63] && r[63] != a[63]);
    @(negedge clk);
    A = a; B = b; sub = s;
    start0 = !sel; start1 = sel;
    n = 0; bc = 0;
    do begin
      @(negedge clk);
      n++;
      start0 = !sel && n == mid;
      start1 = sel && n == mid;
      A = (n == mid) ? {$urandom(), $urandom()} : a;
      B = (n == mid) ? {$urandom(), $urandom()} : b;
      if (n == 2) chk("held_during_run", o_result, prev[sel]);
      if (o_busy && !o_done) bc++;
    end while (!o_done && n < 200);
    chk("latency", 64'(n), 64'(lat));
    chk("busy_cycles", 64'(bc), 64'(lat - 1));
    chk("result", o_result, r);
    chk("nzvc", 64'(o_flags), 64'({r[63], r == 0, v, t[64]}));
    @(negedge clk);
    chk("done_pulse_busy", 64'({o_done, o_busy}), 64'd0);
    chk("result_hold", o_result, r);
    prev[sel] = r;
  endtask
  initial begin
    int k;
    prev[0] = 0; prev[1] = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_busy_done", 64'({busy0, done0, busy1, done1}), 64'd0);
    chk("reset_result", r0, 64'd0);
    chk("reset_flags", 64'({n0, z0, v0, c0}), 64'd0);
    op(64'd5, 64'd3, 1'b1, -1);
    op(64'd3, 64'd5, 1'b1, -1);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, -1);
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, -1);
    op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 10);
    op(64'h8000_0000_0000_0000, 64'd1, 1'b1, -1);
    for (int i = 0; i < 6; i++) op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()), 7);
    @(negedge clk);
    A = 64'd99; B = 64'd1; sub = 0; start0 = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start0 = 0;
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrun_reset_busy_done", 64'({busy0, done0}), 64'd0);
    chk("midrun_reset_result", r0, 64'd0);
    chk("midrun_reset_flags", 64'({n0, z0, v0, c0}), 64'd0);
    k = 0;
    repeat (70) begin
      @(negedge clk);
      if (done0) k++;
    end
    chk("no_done_after_reset", 64'(k), 64'd0);
    prev[0] = 0; prev[1] = 0;
    op(64'd10, 64'd4, 1'b1, -1);
    sel = 1;
    op(64'd5, 64'd3, 1'b1, -1);
    op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 3);
    sel = 0;
`ifdef SERIAL_ADDSUB_ABORT_EN
    op(64'd5, 64'd3, 1'b1, -1);
    @(negedge clk);
    A = 64'd40; B = 64'd1; sub = 0; start0 = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start0 = 0;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy_done", 64'({busy0, done0}), 64'd0);
    chk("abort_result_kept", r0, 64'd2);
    k = 0;
    repeat (70) begin
      @(negedge clk);
      if (done0) k++;
    end
    chk("no_done_after_abort", 64'(k), 64'd0);
    op(64'd8, 64'd8, 1'b0, -1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
